// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, branch redirect
// and multi-cycle MDU handshake, plus saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             idex_is_mdu,
    input  logic             mdu_done,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mdu_start,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MC_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [MC_W-1:0] TIMEOUT_C = MC_W'(MDU_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [MC_W-1:0]   mdu_cnt_r;
    logic [MC_W-1:0]   mdu_cnt_nxt_s;
    logic              mdu_err_r;
    logic              mdu_err_set_s;
    logic              flush_evt_s;
    logic              load_use_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use_s = idex_memread && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    end

    // Same-cycle pipeline controls and next-state decode.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        mdu_start     = 1'b0;
        state_nxt_s   = state_r;
        mdu_cnt_nxt_s = mdu_cnt_r;
        mdu_err_set_s = 1'b0;
        flush_evt_s   = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b1;
            idex_bubble   = 1'b1;
            ifid_flush    = 1'b1;
            state_nxt_s   = ST_RUN;
            mdu_cnt_nxt_s = {MC_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A taken branch flushes the younger MDU op and load-use consumer.
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_evt_s = 1'b1;
                    end else if (idex_is_mdu) begin
                        mdu_start     = 1'b1;
                        pc_write      = 1'b0;
                        ifid_write    = 1'b0;
                        idex_write    = 1'b0;
                        state_nxt_s   = ST_MDU_BUSY;
                        mdu_cnt_nxt_s = MC_W'(1);
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end
                ST_MDU_BUSY: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    if (mdu_done) begin
                        state_nxt_s   = ST_RUN;
                        mdu_cnt_nxt_s = {MC_W{1'b0}};
                    end else if (mdu_cnt_r == TIMEOUT_C) begin
                        // Abandon the hung op: drop it from EX and flag the error.
                        idex_bubble   = 1'b1;
                        mdu_err_set_s = 1'b1;
                        state_nxt_s   = ST_RUN;
                        mdu_cnt_nxt_s = {MC_W{1'b0}};
                    end else begin
                        mdu_cnt_nxt_s = mdu_cnt_r + MC_W'(1);
                    end
                end
                default: begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_bubble   = 1'b1;
                    state_nxt_s   = ST_RUN;
                    mdu_cnt_nxt_s = {MC_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state and MDU busy-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            mdu_cnt_r <= {MC_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mdu_cnt_r <= mdu_cnt_nxt_s;
        end
    end

    // Sticky MDU timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_err_r <= 1'b0;
        end else if (mdu_err_set_s) begin
            mdu_err_r <= 1'b1;
        end else begin
            mdu_err_r <= mdu_err_r;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign mdu_err   = mdu_err_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two configurations driven in lockstep, checked every
// cycle against a behavioural model, with directed scenarios and random traffic.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic idex_memread, idex_is_mdu, mdu_done, branch_taken;

    logic a_pc_write, a_ifid_write, a_idex_write, a_idex_bubble, a_ifid_flush, a_mdu_start, a_mdu_err;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic b_pc_write, b_ifid_write, b_idex_write, b_idex_bubble, b_ifid_flush, b_mdu_start, b_mdu_err;
    logic [3:0] b_stall_cnt, b_flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_is_mdu(idex_is_mdu), .mdu_done(mdu_done),
        .branch_taken(branch_taken), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .idex_write(a_idex_write), .idex_bubble(a_idex_bubble), .ifid_flush(a_ifid_flush),
        .mdu_start(a_mdu_start), .mdu_err(a_mdu_err), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4), .MDU_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .idex_is_mdu(idex_is_mdu), .mdu_done(mdu_done),
        .branch_taken(branch_taken), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .idex_write(b_idex_write), .idex_bubble(b_idex_bubble), .ifid_flush(b_ifid_flush),
        .mdu_start(b_mdu_start), .mdu_err(b_mdu_err), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Model state: is an MDU op outstanding, how many busy cycles so far, sticky error, counters.
    typedef struct packed {
        bit busy;
        int age;
        bit err;
        int stall;
        int flush;
    } mstate_t;

    typedef struct packed {
        bit pc;
        bit ifid;
        bit idw;
        bit bub;
        bit fl;
        bit st;
    } mout_t;

    mstate_t sa, sb;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.busy = 1'b0; s.age = 0; s.err = 1'b0; s.stall = 0; s.flush = 0;
        return s;
    endfunction

    function automatic mout_t model_out(mstate_t s, bit rst, bit lu, bit br, bit mdu, bit done, int tmo);
        mout_t o;
        o.pc = 1'b1; o.ifid = 1'b1; o.idw = 1'b1; o.bub = 1'b0; o.fl = 1'b0; o.st = 1'b0;
        if (!rst) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.idw = 1'b1; o.bub = 1'b1; o.fl = 1'b1;
        end else if (s.busy) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.idw = 1'b0;
            o.bub = !done && (s.age == tmo);
        end else if (br) begin
            o.fl = 1'b1; o.bub = 1'b1;
        end else if (mdu) begin
            o.st = 1'b1; o.pc = 1'b0; o.ifid = 1'b0; o.idw = 1'b0;
        end else if (lu) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1;
        end
        return o;
    endfunction

    function automatic mstate_t model_next(mstate_t s, mout_t o, bit rst, bit br, bit mdu, bit done,
                                           int tmo, int cmax);
        mstate_t n = s;
        if (!rst) return model_reset();
        if (!o.pc && n.stall < cmax) n.stall = n.stall + 1;
        if (s.busy) begin
            if (done) n.busy = 1'b0;
            else if (s.age == tmo) begin n.busy = 1'b0; n.err = 1'b1; end
            else n.age = s.age + 1;
        end else if (br) begin
            if (n.flush < cmax) n.flush = n.flush + 1;
        end else if (mdu) begin
            n.busy = 1'b1; n.age = 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int rs1, input int rs2, input int rd, input bit mr,
                          input bit mdu, input bit done, input bit br);
        ifid_rs1 = 5'(rs1); ifid_rs2 = 5'(rs2); idex_rd = 5'(rd);
        idex_memread = mr; idex_is_mdu = mdu; mdu_done = done; branch_taken = br;
    endtask

    // One clock: check both DUTs mid-cycle against the model, then advance the model.
    task automatic step();
        bit lu;
        mout_t ea, eb;
        @(negedge clk);
        lu = idex_memread && (idex_rd != 5'd0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
        if (!rst_n) begin sa = model_reset(); sb = model_reset(); end
        ea = model_out(sa, rst_n, lu, branch_taken, idex_is_mdu, mdu_done, 64);
        eb = model_out(sb, rst_n, lu, branch_taken, idex_is_mdu, mdu_done, 4);
        chk("a_pc_write", a_pc_write, ea.pc);       chk("b_pc_write", b_pc_write, eb.pc);
        chk("a_ifid_write", a_ifid_write, ea.ifid); chk("b_ifid_write", b_ifid_write, eb.ifid);
        chk("a_idex_write", a_idex_write, ea.idw);  chk("b_idex_write", b_idex_write, eb.idw);
        chk("a_idex_bubble", a_idex_bubble, ea.bub); chk("b_idex_bubble", b_idex_bubble, eb.bub);
        chk("a_ifid_flush", a_ifid_flush, ea.fl);   chk("b_ifid_flush", b_ifid_flush, eb.fl);
        chk("a_mdu_start", a_mdu_start, ea.st);     chk("b_mdu_start", b_mdu_start, eb.st);
        chk("a_mdu_err", a_mdu_err, sa.err);        chk("b_mdu_err", b_mdu_err, sb.err);
        chk("a_stall_cnt", a_stall_cnt, sa.stall);  chk("b_stall_cnt", b_stall_cnt, sb.stall);
        chk("a_flush_cnt", a_flush_cnt, sa.flush);  chk("b_flush_cnt", b_flush_cnt, sb.flush);
        sa = model_next(sa, ea, rst_n, branch_taken, idex_is_mdu, mdu_done, 64, 65535);
        sb = model_next(sb, eb, rst_n, branch_taken, idex_is_mdu, mdu_done, 4, 15);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        sa = model_reset();
        sb = model_reset();
        repeat (2) step();
        rst_n = 1'b1;

        // No hazard.
        set_in(2, 3, 5, 0, 0, 0, 0); step();
        chk("pin_nohaz_stall", a_stall_cnt, 0);
        chk("pin_nohaz_pc", a_pc_write, 1);
        // Load-use stalls exactly one cycle; rd=0 never stalls.
        set_in(5, 0, 5, 1, 0, 0, 0); step();
        chk("pin_lu_stall", a_stall_cnt, 1);
        set_in(5, 0, 0, 1, 0, 0, 0); step();
        chk("pin_rd0_stall", a_stall_cnt, 1);
        // Branch wins over load-use.
        set_in(0, 7, 7, 1, 0, 0, 1); step();
        chk("pin_br_flush", a_flush_cnt, 1);
        chk("pin_br_stall", a_stall_cnt, 1);
        // MDU op completing on the 10th busy cycle (B times out after 4).
        set_in(1, 2, 3, 0, 1, 0, 0); step();
        set_in(1, 2, 3, 0, 0, 0, 0); repeat (9) step();
        set_in(1, 2, 3, 0, 0, 1, 0); step();
        chk("pin_mdu_stall_a", a_stall_cnt, 12);
        chk("pin_mdu_err_a", a_mdu_err, 0);
        chk("pin_tmo_err_b", b_mdu_err, 1);
        chk("pin_tmo_stall_b", b_stall_cnt, 6);
        set_in(1, 2, 3, 0, 0, 0, 0); step();
        // Reset pulse clears error and counters.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("pin_rst_err_b", b_mdu_err, 0);
        chk("pin_rst_stall_b", b_stall_cnt, 0);
        chk("pin_rst_flush_a", a_flush_cnt, 0);
        // Saturation of the 4-bit counter.
        set_in(5, 0, 5, 1, 0, 0, 0); repeat (20) step();
        chk("pin_sat_b", b_stall_cnt, 15);
        chk("pin_sat_a", a_stall_cnt, 20);
        // Reset in the middle of an MDU op: no re-issued start afterwards.
        set_in(1, 2, 3, 0, 1, 0, 0); step();
        set_in(1, 2, 3, 0, 0, 0, 0); repeat (3) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (5) step();
        chk("pin_midrst_start", a_mdu_start, 0);
        chk("pin_midrst_pc", a_pc_write, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
